// File: rtl/y86_pkg.sv
// Purpose: shared Y86-64 encodings and the E-stage register layout.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package y86_pkg;

    localparam int XLEN = 64;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register specifiers
    localparam logic [3:0] RRSP  = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    // Status codes
    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    typedef struct packed {
        logic [1:0]      stat;
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [XLEN-1:0] valC;
        logic [XLEN-1:0] valA;
        logic [XLEN-1:0] valB;
        logic [3:0]      dstE;
        logic [3:0]      dstM;
        logic [3:0]      srcA;
        logic [3:0]      srcB;
    } ereg_t;

    // Nop inserted into the E stage on bubble and at reset
    localparam ereg_t EREG_BUBBLE = '{
        stat:  SAOK,
        icode: INOP,
        ifun:  4'h0,
        valC:  '0,
        valA:  '0,
        valB:  '0,
        dstE:  RNONE,
        dstM:  RNONE,
        srcA:  RNONE,
        srcB:  RNONE
    };

endpackage

// File: rtl/regfile.sv
// Purpose: Y86-64 register file, NREG x WIDTH, 2 comb read ports, 2 write ports.
// Latency: reads combinational; writes land at posedge clk.
// Backpressure: none; index RNONE (or any index >= NREG) reads 0 and drops writes.
// Ports: clk/rst, raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o,
//        wdst_e_i/wval_e_i, wdst_m_i/wval_m_i (M port wins on collision).
module regfile #(
    parameter int WIDTH = 64,
    parameter int NREG  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       raddr_a_i,
    output logic [WIDTH-1:0] rdata_a_o,
    input  logic [3:0]       raddr_b_i,
    output logic [WIDTH-1:0] rdata_b_o,
    input  logic [3:0]       wdst_e_i,
    input  logic [WIDTH-1:0] wval_e_i,
    input  logic [3:0]       wdst_m_i,
    input  logic [WIDTH-1:0] wval_m_i
);

    logic [WIDTH-1:0] regs_q [NREG];

    assign rdata_a_o = (32'(raddr_a_i) < NREG) ? regs_q[raddr_a_i] : '0;
    assign rdata_b_o = (32'(raddr_b_i) < NREG) ? regs_q[raddr_b_i] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (32'(wdst_e_i) < NREG) begin
                regs_q[wdst_e_i] <= wval_e_i;
            end
            // Issued after the E write so valM takes the register on a collision
            if (32'(wdst_m_i) < NREG) begin
                regs_q[wdst_m_i] <= wval_m_i;
            end
        end
    end

endmodule

// File: rtl/decode_ereg.sv
// Purpose: Y86-64 decode (src/dst select, forwarded operand read, W writeback) + E pipeline register.
// Latency: 1 cycle d_* -> E_*; d_srcA/d_srcB combinational.
// Backpressure: E_stall holds E (priority), E_bubble loads a nop.
// Ports: d_* decode fields in; e_/M_/W_ forwarding and writeback sources in;
//        E_stall/E_bubble control in; d_srcA/d_srcB and registered E_* out.
module decode_ereg
    import y86_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREG  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       d_stat,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_ifun,
    input  logic [3:0]       d_rA,
    input  logic [3:0]       d_rB,
    input  logic [WIDTH-1:0] d_valC,
    input  logic [WIDTH-1:0] d_valP,
    input  logic [3:0]       e_dstE,
    input  logic [WIDTH-1:0] e_valE,
    input  logic [3:0]       M_dstE,
    input  logic [WIDTH-1:0] M_valE,
    input  logic [3:0]       M_dstM,
    input  logic [WIDTH-1:0] m_valM,
    input  logic [3:0]       W_dstE,
    input  logic [WIDTH-1:0] W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [WIDTH-1:0] W_valM,
    input  logic             E_stall,
    input  logic             E_bubble,
    output logic [3:0]       d_srcA,
    output logic [3:0]       d_srcB,
    output logic [1:0]       E_stat,
    output logic [3:0]       E_icode,
    output logic [3:0]       E_ifun,
    output logic [WIDTH-1:0] E_valC,
    output logic [WIDTH-1:0] E_valA,
    output logic [WIDTH-1:0] E_valB,
    output logic [3:0]       E_dstE,
    output logic [3:0]       E_dstM,
    output logic [3:0]       E_srcA,
    output logic [3:0]       E_srcB
);

    logic [3:0]       src_a, src_b, dst_e, dst_m;
    logic [WIDTH-1:0] rf_a, rf_b, val_a, val_b;
    ereg_t            ereg_d, ereg_q;

    // Register specifier selection
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d_icode)
            IRRMOVQ: begin src_a = d_rA; dst_e = d_rB; end
            IIRMOVQ: begin dst_e = d_rB; end
            IRMMOVQ: begin src_a = d_rA; src_b = d_rB; end
            IMRMOVQ: begin src_b = d_rB; dst_m = d_rA; end
            IOPQ:    begin src_a = d_rA; src_b = d_rB; dst_e = d_rB; end
            IPUSHQ:  begin src_a = d_rA; src_b = RRSP; dst_e = RRSP; end
            IPOPQ:   begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; dst_m = d_rA; end
            ICALL:   begin src_b = RRSP; dst_e = RRSP; end
            IRET:    begin src_a = RRSP; src_b = RRSP; dst_e = RRSP; end
            default: ;
        endcase
    end

    assign d_srcA = src_a;
    assign d_srcB = src_b;

    regfile #(.WIDTH(WIDTH), .NREG(NREG)) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .raddr_a_i (src_a),
        .rdata_a_o (rf_a),
        .raddr_b_i (src_b),
        .rdata_b_o (rf_b),
        .wdst_e_i  (W_dstE),
        .wval_e_i  (W_valE),
        .wdst_m_i  (W_dstM),
        .wval_m_i  (W_valM)
    );

    // Forwarding: youngest producer first; M-stage load beats M-stage ALU result.
    // RNONE is tested first so an idle stage advertising RNONE never forwards.
    always_comb begin
        if (d_icode == ICALL || d_icode == IJXX) val_a = d_valP;
        else if (src_a == RNONE)                 val_a = '0;
        else if (src_a == e_dstE)                val_a = e_valE;
        else if (src_a == M_dstM)                val_a = m_valM;
        else if (src_a == M_dstE)                val_a = M_valE;
        else if (src_a == W_dstM)                val_a = W_valM;
        else if (src_a == W_dstE)                val_a = W_valE;
        else                                     val_a = rf_a;
    end

    always_comb begin
        if (src_b == RNONE)       val_b = '0;
        else if (src_b == e_dstE) val_b = e_valE;
        else if (src_b == M_dstM) val_b = m_valM;
        else if (src_b == M_dstE) val_b = M_valE;
        else if (src_b == W_dstM) val_b = W_valM;
        else if (src_b == W_dstE) val_b = W_valE;
        else                      val_b = rf_b;
    end

    always_comb begin
        ereg_d = ereg_q;
        if (E_stall) begin
            ereg_d = ereg_q;
        end else if (E_bubble) begin
            ereg_d = EREG_BUBBLE;
        end else begin
            ereg_d.stat  = d_stat;
            ereg_d.icode = d_icode;
            ereg_d.ifun  = d_ifun;
            ereg_d.valC  = d_valC;
            ereg_d.valA  = val_a;
            ereg_d.valB  = val_b;
            ereg_d.dstE  = dst_e;
            ereg_d.dstM  = dst_m;
            ereg_d.srcA  = src_a;
            ereg_d.srcB  = src_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ereg_q <= EREG_BUBBLE;
        else     ereg_q <= ereg_d;
    end

    assign E_stat  = ereg_q.stat;
    assign E_icode = ereg_q.icode;
    assign E_ifun  = ereg_q.ifun;
    assign E_valC  = ereg_q.valC;
    assign E_valA  = ereg_q.valA;
    assign E_valB  = ereg_q.valB;
    assign E_dstE  = ereg_q.dstE;
    assign E_dstM  = ereg_q.dstM;
    assign E_srcA  = ereg_q.srcA;
    assign E_srcB  = ereg_q.srcB;

endmodule

// File: tb/tb_decode_ereg.sv
// Purpose: directed self-checking bench for decode_ereg.
// Latency: checks sampled 1 time unit after the capturing posedge.
// Backpressure: exercises E_stall / E_bubble directly.
module tb_decode_ereg;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  d_stat;
    logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
    logic [63:0] d_valC, d_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic        E_stall, E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_ereg dut (
        .clk(clk), .rst(rst),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
        .d_rA(d_rA), .d_rB(d_rB), .d_valC(d_valC), .d_valP(d_valP),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstE(M_dstE), .M_valE(M_valE), .M_dstM(M_dstM), .m_valM(m_valM),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [3:0] icode, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp);
        d_icode = icode; d_ifun = 4'h0; d_rA = ra; d_rB = rb;
        d_valC = valc; d_valP = valp; d_stat = 2'd0;
    endtask

    task automatic idle_fwd();
        e_dstE = 4'hF; e_valE = '0;
        M_dstE = 4'hF; M_valE = '0; M_dstM = 4'hF; m_valM = '0;
        W_dstE = 4'hF; W_valE = '0; W_dstM = 4'hF; W_valM = '0;
    endtask

    initial begin
        rst = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
        idle_fwd();
        dec(4'h1, 4'hF, 4'hF, '0, '0);
        #1;
        // Reset state: E holds the bubble
        check("rst_icode", E_icode, 64'h1);
        check("rst_dstE",  E_dstE, 64'hF);
        check("rst_srcA",  E_srcA, 64'hF);
        check("rst_valA",  E_valA, 64'h0);
        check("nop_srcA",  d_srcA, 64'hF);
        tick();
        rst = 1'b0;

        // Write %rax=5, %rbx=7
        W_dstE = 4'h0; W_valE = 64'd5; W_dstM = 4'h3; W_valM = 64'd7;
        tick();
        idle_fwd();
        dec(4'h2, 4'h0, 4'h2, '0, '0);          // rrmovq %rax,%rdx
        #1 check("rr_dsrcA", d_srcA, 64'h0);
        tick();
        check("rr_valA", E_valA, 64'd5);
        check("rr_dstE", E_dstE, 64'h2);
        check("rr_srcA", E_srcA, 64'h0);
        check("rr_icode", E_icode, 64'h2);

        // OPq rA=1 rB=2: e beats M
        dec(4'h6, 4'h1, 4'h2, '0, '0);
        e_dstE = 4'h1; e_valE = 64'h11; M_dstE = 4'h1; M_valE = 64'h22;
        tick();
        check("op_e_over_M", E_valA, 64'h11);
        check("op_valB", E_valB, 64'h0);
        check("op_dstE", E_dstE, 64'h2);

        // m_valM beats M_valE beats W
        idle_fwd();
        M_dstM = 4'h1; m_valM = 64'h44; M_dstE = 4'h1; M_valE = 64'h22;
        W_dstE = 4'h1; W_valE = 64'h33;
        tick();
        check("op_mM_over_ME", E_valA, 64'h44);
        idle_fwd();
        M_dstE = 4'h1; M_valE = 64'h22; W_dstM = 4'h1; W_valM = 64'h55;
        tick();
        check("op_ME_over_W", E_valA, 64'h22);

        // popq rA=3 with W writing %rsp=0x100
        idle_fwd();
        dec(4'hB, 4'h3, 4'hF, '0, '0);
        W_dstE = 4'h4; W_valE = 64'h100;
        tick();
        check("pop_valA", E_valA, 64'h100);
        check("pop_valB", E_valB, 64'h100);
        check("pop_dstE", E_dstE, 64'h4);
        check("pop_dstM", E_dstM, 64'h3);

        // %rsp=0x200, then call valP=0x40
        W_valE = 64'h200;
        dec(4'h1, 4'hF, 4'hF, '0, '0);
        tick();
        idle_fwd();
        dec(4'h8, 4'hF, 4'hF, 64'h80, 64'h40);
        tick();
        check("call_valA", E_valA, 64'h40);
        check("call_valB", E_valB, 64'h200);
        check("call_dstE", E_dstE, 64'h4);
        check("call_srcA", E_srcA, 64'hF);

        // pushq %rbx reads the earlier W_dstM write
        dec(4'hA, 4'h3, 4'hF, '0, '0);
        tick();
        check("push_valA", E_valA, 64'd7);
        check("push_valB", E_valB, 64'h200);

        // Collision on %rsi: valM wins
        W_dstE = 4'h6; W_valE = 64'd1; W_dstM = 4'h6; W_valM = 64'd2;
        dec(4'h1, 4'hF, 4'hF, '0, '0);
        tick();
        idle_fwd();
        dec(4'h2, 4'h6, 4'h7, '0, '0);
        tick();
        check("collide_rsi", E_valA, 64'd2);

        // irmovq: RNONE source never forwards; status passes through
        dec(4'h3, 4'hF, 4'h5, 64'h1234, '0);
        d_stat = 2'd2;
        e_dstE = 4'hF; e_valE = 64'h99;
        tick();
        idle_fwd();
        check("irm_valA_rnone", E_valA, 64'h0);
        check("irm_valC", E_valC, 64'h1234);
        check("irm_dstE", E_dstE, 64'h5);
        check("irm_stat", E_stat, 64'd2);

        // Stall + bubble: hold
        dec(4'h6, 4'h1, 4'h2, '0, '0);
        E_stall = 1'b1; E_bubble = 1'b1;
        tick();
        check("stall_icode", E_icode, 64'h3);
        check("stall_valC", E_valC, 64'h1234);

        // Bubble only
        E_stall = 1'b0;
        tick();
        check("bub_icode", E_icode, 64'h1);
        check("bub_dstE", E_dstE, 64'hF);
        check("bub_valC", E_valC, 64'h0);
        E_bubble = 1'b0;

        // Load something, then async reset mid-cycle
        dec(4'h2, 4'h0, 4'h2, '0, '0);
        tick();
        check("pre_rst_valA", E_valA, 64'd5);
        #2 rst = 1'b1;
        #1 check("async_rst_icode", E_icode, 64'h1);
        check("async_rst_valA", E_valA, 64'h0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_rax", E_valA, 64'h0);
        dec(4'hA, 4'h6, 4'hF, '0, '0);
        tick();
        check("post_rst_rsi", E_valA, 64'h0);
        check("post_rst_rsp", E_valB, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_ereg.md
Name: decode_ereg

Overview:
- Y86-64 decode stage plus execute pipeline register.
- Consumes decoded-instruction fields from the decode pipeline register and computes srcA, srcB, dstE and dstM.
- Reads the 15-entry register file with full forwarding from the E, M and W stages, and performs register-file writeback from the W stage.
- Latches the result into the E-stage register, with stall and bubble control driven by the pipeline control logic.

Parameters:
- WIDTH, 64, datapath width.
- NREG, 15, architectural registers %rax..%r14; index 4'hF = RNONE.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- d_stat  in  2  decode-stage status.
- d_icode  in  4  decode-stage instruction code.
- d_ifun  in  4  decode-stage function code.
- d_rA  in  4  register specifier A.
- d_rB  in  4  register specifier B.
- d_valC  in  64  constant word.
- d_valP  in  64  incremented PC.
- e_dstE  in  4  execute-stage destination E.
- e_valE  in  64  execute-stage result.
- M_dstE  in  4  memory-stage destination E.
- M_valE  in  64  memory-stage E value.
- M_dstM  in  4  memory-stage destination M.
- m_valM  in  64  memory-stage load result.
- W_dstE  in  4  writeback destination E.
- W_valE  in  64  writeback E value.
- W_dstM  in  4  writeback destination M.
- W_valM  in  64  writeback M value.
- E_stall  in  1  hold the E register.
- E_bubble  in  1  load a nop into the E register.
- d_srcA  out  4  combinational srcA, for hazard detection.
- d_srcB  out  4  combinational srcB, for hazard detection.
- E_stat, E_icode, E_ifun  out  2/4/4  registered.
- E_valC, E_valA, E_valB  out  64 each  registered.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered.

Behaviour:
- Reset: one clock, clk; reset rst is asynchronous and active-high.
  - While rst=1, all 15 registers are 0.
  - E register holds the bubble: stat=AOK, icode=NOP(1), ifun=0, all 64-bit values 0, dst/src=RNONE.
- srcA:
  - rA for rrmovq(2), rmmovq(4), OPq(6), pushq(A).
  - RSP(4) for popq(B), ret(9).
  - Otherwise RNONE.
- srcB:
  - rB for OPq, rmmovq, mrmovq(5).
  - RSP for pushq, popq, call(8), ret.
  - Otherwise RNONE.
- dstE:
  - rB for rrmovq/cmovXX, irmovq(3), OPq.
  - RSP for pushq, popq, call, ret.
  - Otherwise RNONE.
  - The cmov condition is resolved in execute, not here.
- dstM: rA for mrmovq, popq; otherwise RNONE.
- valA selection, first match wins:
  1. icode call or jXX(7) → d_valP.
  2. srcA==e_dstE → e_valE.
  3. srcA==M_dstM → m_valM.
  4. srcA==M_dstE → M_valE.
  5. srcA==W_dstM → W_valM.
  6. srcA==W_dstE → W_valE.
  7. Otherwise register-file read.
  - A source of RNONE never matches and yields 0.
- valB: same chain as valA, without the valP rule.
- Register file:
  - Reads are combinational, so a W write in the same cycle is visible only through forwarding.
  - Writes occur at posedge: W_dstE←W_valE and W_dstM←W_valM.
  - If both target the same register, W_valM wins.
  - Writes to RNONE are ignored.
- E register update at posedge:
  - E_stall=1: hold all values. Stall has priority over bubble.
  - Else E_bubble=1: load the bubble values.
  - Else: load the decode results.
  - Latency: 1 cycle from d_* to E_*.
- Status: d_stat passes through unchanged; no decode-side status is generated.
- Reset mid-operation: asynchronous clear of both the register file and the E register; any in-flight writeback is lost.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants IHALT..IPOPQ.
  - RNONE, RRSP.
  - Stat codes SAOK=0, SHLT=1, SADR=2, SINS=3.
  - Bubble-value constants.
- Sub-module regfile:
  - 15×64 storage.
  - 2 combinational read ports, 2 write ports.
  - Asynchronous reset.

Test Plan:
- Reset, then W writes %rax=5 (W_dstE=0) and %rbx=7 (W_dstM=3); next decode rrmovq rA=0 → E_valA=5, E_dstE=rB, E_srcA=0 after one clock.
- OPq rA=1,rB=2 with e_dstE=1,e_valE=0x11 and M_dstE=1,M_valE=0x22 → E_valA=0x11, proving priority.
- popq rA=3 with W_dstE=4,W_valE=0x100 and no newer writer → E_valA=E_valB=0x100, E_dstE=4, E_dstM=3.
- call with valP=0x40 and srcB=RSP, where %rsp=0x200 was written earlier → E_valA=0x40, E_valB=0x200, E_dstE=4.
- Simultaneous W_dstE=W_dstM=6 with valE=1, valM=2 → a later read of %rsi returns 2.
- E_bubble=1 → E_icode=1, dst=RNONE; E_stall and E_bubble both 1 → E unchanged.
- rst asserted mid-stream → E returns to the bubble immediately, and all registers read 0 afterwards.
